// File: rtl/jtdsp16_do_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtdsp16_do_ctrl_pkg
// Brief    : Shared state encoding and field widths for the do-loop sequencer.
// Revision : 1.0  initial release
// ============================================================================
package jtdsp16_do_ctrl_pkg;

   localparam int NI_W_DEF = 4;
   localparam int K_W_DEF  = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_LOOP = 2'd2
   } do_state_t;

endpackage
`default_nettype wire

// File: rtl/jtdsp16_do_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtdsp16_do_ctrl
// Brief    : DSP16 do/redo loop sequencer; first pass fills from ROM, then
//            the remaining passes replay from the loop cache with PC held.
// Revision : 1.0  initial release
// ============================================================================
module jtdsp16_do_ctrl
   import jtdsp16_do_ctrl_pkg::*;
#(
   parameter int NI_W = NI_W_DEF,
   parameter int K_W  = K_W_DEF
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cen,
   input  logic                 do_cmd,
   input  logic [NI_W+K_W-1:0]  i_field,
   input  logic                 ins_done,
   output logic                 do_save,
   output logic                 do_start,
   output logic                 do_redo,
   output logic                 do_out,
   output logic                 do_short,
   output logic [NI_W-1:0]      do_pc,
   output logic [NI_W+K_W-1:0]  do_data,
   output logic                 loop_busy,
   output logic                 do_err
);

   do_state_t          r_state;
   logic [NI_W-1:0]    r_ni;
   logic [NI_W-1:0]    r_cnt;
   logic [NI_W-1:0]    r_pc;
   logic [K_W-1:0]     r_iter;
   logic               r_valid;
   logic               r_short;
   logic               r_busy;

   logic [NI_W-1:0]    w_ni;
   logic [K_W-1:0]     w_k;
   logic               w_en;
   logic               w_idle;
   logic               w_fill;
   logic               w_loop;
   logic               w_ni_nz;
   logic               w_k_nz;
   logic               w_iter_one;
   logic               w_fill_last;
   logic               w_pass_end;
   logic               w_new_do;
   logic               w_redo_ok;
   logic               w_redo_bad;
   logic               w_busy_cmd;
   logic               w_fill_go;
   logic               w_exit;

   assign w_ni       = i_field[NI_W+K_W-1:K_W];
   assign w_k        = i_field[K_W-1:0];
   // strobes are silenced while reset is held so every output reads zero
   assign w_en       = cen & rst_n;
   assign w_idle     = (r_state == ST_IDLE);
   assign w_fill     = (r_state == ST_FILL);
   assign w_loop     = (r_state == ST_LOOP);
   assign w_ni_nz    = (w_ni != '0);
   assign w_k_nz     = (w_k != '0);
   assign w_iter_one = (r_iter == K_W'(1));
   assign w_fill_last = w_fill & ins_done & (r_cnt == r_ni - NI_W'(1));
   assign w_pass_end  = w_loop & ins_done & (r_pc == r_ni);

   assign w_new_do   = w_en & w_idle & do_cmd & w_ni_nz & w_k_nz;
   assign w_redo_ok  = w_en & w_idle & do_cmd & ~w_ni_nz & r_valid & w_k_nz;
   assign w_redo_bad = w_en & w_idle & do_cmd & ~w_ni_nz & ~(r_valid & w_k_nz);
   assign w_busy_cmd = w_en & ~w_idle & do_cmd;
   assign w_fill_go  = w_en & w_fill_last & ~w_iter_one;
   assign w_exit     = w_en & w_pass_end & w_iter_one;

   assign do_save    = w_new_do;
   assign do_start   = w_redo_ok | w_fill_go;
   assign do_redo    = w_redo_ok;
   assign do_out     = w_exit;
   assign do_err     = w_redo_bad | w_busy_cmd;

   assign do_short   = r_short;
   assign do_pc      = r_pc;
   assign do_data    = {r_ni, r_iter};
   assign loop_busy  = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ni    <= '0;
         r_cnt   <= '0;
         r_pc    <= '0;
         r_iter  <= '0;
         r_valid <= 1'b0;
         r_short <= 1'b0;
         r_busy  <= 1'b0;
      end else if (cen) begin
         case (r_state)
            ST_IDLE: begin
               if (do_cmd) begin
                  if (w_ni_nz) begin
                     if (w_k_nz) begin
                        r_ni    <= w_ni;
                        r_iter  <= w_k;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_short <= (w_ni == NI_W'(1));
                        r_state <= ST_FILL;
                        r_busy  <= 1'b1;
                     end
                  end else if (r_valid && w_k_nz) begin
                     // redo: every pass comes from the cache, head already saved
                     r_iter  <= w_k;
                     r_pc    <= NI_W'(1);
                     r_state <= ST_LOOP;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (ins_done) begin
                  r_cnt <= r_cnt + NI_W'(1);
                  if (r_cnt == r_ni - NI_W'(1)) begin
                     if (r_iter == K_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_iter  <= r_iter - K_W'(1);
                        r_pc    <= NI_W'(1);
                        r_state <= ST_LOOP;
                     end
                  end
               end
            end
            ST_LOOP: begin
               if (ins_done) begin
                  if (r_pc == r_ni) begin
                     if (r_iter == K_W'(1)) begin
                        r_pc    <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_iter <= r_iter - K_W'(1);
                        r_pc   <= NI_W'(1);
                     end
                  end else begin
                     r_pc <= r_pc + NI_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_do_ctrl.sv
`default_nettype none
// Self-checking bench for jtdsp16_do_ctrl: expected per-cycle outputs are queued
// alongside the stimulus and compared as each cycle is driven.
module tb_jtdsp16_do_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic        do_cmd = 1'b0;
   logic [10:0] i_field = '0;
   logic        ins_done = 1'b0;
   logic        do_save, do_start, do_redo, do_out, do_short, loop_busy, do_err;
   logic [3:0]  do_pc;
   logic [10:0] do_data;

   jtdsp16_do_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .do_cmd(do_cmd), .i_field(i_field),
      .ins_done(ins_done), .do_save(do_save), .do_start(do_start), .do_redo(do_redo),
      .do_out(do_out), .do_short(do_short), .do_pc(do_pc), .do_data(do_data),
      .loop_busy(loop_busy), .do_err(do_err)
   );

   always #5 clk = ~clk;

   // expected layout: {save,start,redo,out,err,busy,short,pc[3:0],data[10:0]}
   typedef struct packed {
      logic        cmd;
      logic [10:0] fld;
      logic        ins;
      logic        en;
      logic [21:0] exp;
   } ent_t;

   ent_t        q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   logic        sh = 1'b0;
   logic [10:0] dd = '0;
   logic        vld = 1'b0;
   int          vni = 0;

   function automatic logic [21:0] obs_vec();
      return {do_save, do_start, do_redo, do_out, do_err, loop_busy, do_short, do_pc, do_data};
   endfunction

   function automatic void pe(input logic cmd, input logic [10:0] fld, input logic ins,
                              input logic en, input logic s, input logic st, input logic rd,
                              input logic o, input logic er, input logic b, input logic [3:0] pc);
      ent_t e;
      e.cmd = cmd; e.fld = fld; e.ins = ins; e.en = en;
      e.exp = {s, st, rd, o, er, b, sh, pc, dd};
      q.push_back(e);
   endfunction

   function automatic void push_idle(input int n);
      for (int i = 0; i < n; i++) pe(1'b0, 11'd0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 4'd0);
   endfunction

   // do NI,K with one retire per cycle, starting and ending in IDLE
   function automatic void push_do(input int ni, input int k);
      logic [10:0] f;
      f = {4'(ni), 7'(k)};
      if (k == 0) begin
         pe(1'b1, f, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 4'd0);
         return;
      end
      pe(1'b1, f, 1'b1, 1'b1, 1, 0, 0, 0, 0, 0, 4'd0);
      sh = (ni == 1); dd = {4'(ni), 7'(k)}; vld = 1'b1; vni = ni;
      for (int c = 1; c <= ni; c++)
         pe(1'b0, 11'd0, 1'b1, 1'b1, 0, (c == ni && k > 1), 0, 0, 0, 1, 4'd0);
      for (int p = 1; p < k; p++) begin
         dd = {4'(ni), 7'(k - p)};
         for (int j = 1; j <= ni; j++)
            pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, (p == k - 1 && j == ni), 0, 1, 4'(j));
      end
   endfunction

   function automatic void push_redo(input int k);
      logic [10:0] f;
      f = {4'd0, 7'(k)};
      if (!(vld && k != 0)) begin
         pe(1'b1, f, 1'b1, 1'b1, 0, 0, 0, 0, 1, 0, 4'd0);
         return;
      end
      pe(1'b1, f, 1'b1, 1'b1, 0, 1, 1, 0, 0, 0, 4'd0);
      for (int p = 1; p <= k; p++) begin
         dd = {4'(vni), 7'(k - p + 1)};
         for (int j = 1; j <= vni; j++)
            pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, (p == k && j == vni), 0, 1, 4'(j));
      end
   endfunction

   task automatic step(input ent_t e, output logic [21:0] o);
      @(negedge clk);
      do_cmd = e.cmd; i_field = e.fld; ins_done = e.ins; cen = e.en;
      #1;
      o = obs_vec();
   endtask

   task automatic test_reset();
      logic [21:0] o;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      do_cmd = 1'b1; i_field = {4'd3, 7'd2}; cen = 1'b1; ins_done = 1'b1;
      #1;
      o = obs_vec();
      n_chk++;
      if (o !== 22'd0) $display("FAIL reset_outputs got %h expected %h", o, 22'd0);
      else n_pass++;
      @(negedge clk);
      do_cmd = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_redo_no_loop();
      ent_t e; logic [21:0] o; int c = 0;
      push_redo(3); push_idle(1);
      push_do(3, 0); push_idle(1);
      while (q.size() > 0) begin
         e = q.pop_front(); step(e, o); n_chk++;
         if (o !== e.exp) $display("FAIL redo_no_loop cyc %0d got %h expected %h", c, o, e.exp);
         else n_pass++;
         c++;
      end
   endtask

   task automatic test_do_loop(input int ni, input int k);
      ent_t e; logic [21:0] o; int c = 0;
      push_do(ni, k); push_idle(1);
      while (q.size() > 0) begin
         e = q.pop_front(); step(e, o); n_chk++;
         if (o !== e.exp)
            $display("FAIL do_ni%0d_k%0d cyc %0d got %h expected %h", ni, k, c, o, e.exp);
         else n_pass++;
         c++;
      end
   endtask

   task automatic test_redo(input int k);
      ent_t e; logic [21:0] o; int c = 0;
      push_redo(k); push_idle(1);
      while (q.size() > 0) begin
         e = q.pop_front(); step(e, o); n_chk++;
         if (o !== e.exp) $display("FAIL redo_k%0d cyc %0d got %h expected %h", k, c, o, e.exp);
         else n_pass++;
         c++;
      end
   endtask

   task automatic test_stall_cen();
      ent_t e; logic [21:0] o; int c = 0;
      logic [10:0] f;
      f = {4'd2, 7'd3};
      pe(1'b1, f, 1'b1, 1'b1, 1, 0, 0, 0, 0, 0, 4'd0);
      sh = 1'b0; dd = f; vld = 1'b1; vni = 2;
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd0);
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 1, 0, 0, 0, 1, 4'd0);
      dd = {4'd2, 7'd2};
      pe(1'b0, 11'd0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1, 4'd1);
      pe(1'b0, 11'd0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1, 4'd1);
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd1);
      pe(1'b0, 11'd0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1, 4'd2);
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd2);
      dd = {4'd2, 7'd1};
      pe(1'b1, f,     1'b0, 1'b1, 0, 0, 0, 0, 1, 1, 4'd1);
      pe(1'b1, f,     1'b1, 1'b0, 0, 0, 0, 0, 0, 1, 4'd1);
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd1);
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 1, 0, 1, 4'd2);
      push_idle(1);
      while (q.size() > 0) begin
         e = q.pop_front(); step(e, o); n_chk++;
         if (o !== e.exp) $display("FAIL stall_cen cyc %0d got %h expected %h", c, o, e.exp);
         else n_pass++;
         c++;
      end
   endtask

   task automatic test_reset_mid_loop();
      ent_t e; logic [21:0] o; int c = 0;
      logic [10:0] f;
      f = {4'd2, 7'd3};
      pe(1'b1, f, 1'b1, 1'b1, 1, 0, 0, 0, 0, 0, 4'd0);
      sh = 1'b0; dd = f; vld = 1'b1; vni = 2;
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd0);
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 1, 0, 0, 0, 1, 4'd0);
      dd = {4'd2, 7'd2};
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd1);
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd2);
      dd = {4'd2, 7'd1};
      pe(1'b0, 11'd0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 4'd1);
      while (q.size() > 0) begin
         e = q.pop_front(); step(e, o); n_chk++;
         if (o !== e.exp) $display("FAIL pre_reset cyc %0d got %h expected %h", c, o, e.exp);
         else n_pass++;
         c++;
      end
      @(negedge clk);
      do_cmd = 1'b0; ins_done = 1'b1; cen = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      o = obs_vec();
      n_chk++;
      if (o !== 22'd0) $display("FAIL async_reset got %h expected %h", o, 22'd0);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      sh = 1'b0; dd = '0; vld = 1'b0; vni = 0;
      push_idle(1); push_redo(2); push_idle(1);
      c = 0;
      while (q.size() > 0) begin
         e = q.pop_front(); step(e, o); n_chk++;
         if (o !== e.exp) $display("FAIL post_reset cyc %0d got %h expected %h", c, o, e.exp);
         else n_pass++;
         c++;
      end
   endtask

   initial begin
      test_reset();
      test_redo_no_loop();
      test_do_loop(3, 4);
      test_redo(2);
      test_do_loop(2, 1);
      test_do_loop(1, 3);
      test_redo(0);
      test_do_loop(15, 2);
      test_stall_cen();
      test_reset_mid_loop();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
